// File: rtl/hyperbus_cfg_init_seq.sv
// hyperbus_cfg_init_seq: replays a fixed list of config writes after reset, then passes the host through.
module hyperbus_cfg_init_seq #(
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned NumInit = 4,
  parameter logic [(NumInit > 0 ? NumInit : 1)-1:0][RegAddrWidth-1:0] InitAddr = '0,
  parameter logic [(NumInit > 0 ? NumInit : 1)-1:0][RegDataWidth-1:0] InitData = '0,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rerun_i,
  input  logic                      host_valid_i,
  input  logic                      host_write_i,
  input  logic [RegAddrWidth-1:0]   host_addr_i,
  input  logic [RegDataWidth-1:0]   host_wdata_i,
  input  logic [RegDataWidth/8-1:0] host_wstrb_i,
  output logic                      host_ready_o,
  output logic [RegDataWidth-1:0]   host_rdata_o,
  output logic                      host_error_o,
  output logic                      cfg_valid_o,
  output logic                      cfg_write_o,
  output logic [RegAddrWidth-1:0]   cfg_addr_o,
  output logic [RegDataWidth-1:0]   cfg_wdata_o,
  output logic [RegDataWidth/8-1:0] cfg_wstrb_o,
  input  logic                      cfg_ready_i,
  input  logic [RegDataWidth-1:0]   cfg_rdata_i,
  input  logic                      cfg_error_i,
  output logic                      done_o,
  output logic                      init_err_o,
  output logic                      timeout_o
);
  localparam int unsigned NE = NumInit > 0 ? NumInit : 1;
  localparam int unsigned IW = NE > 1 ? $clog2(NE) : 1;
  localparam int unsigned TW = $clog2(TimeoutCycles + 1);
  localparam logic [IW-1:0] LAST = IW'(NE - 1);
  localparam logic [TW-1:0] TMAX = TW'(TimeoutCycles - 1);
  typedef enum logic {INIT, PASS} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic pending, expire, adv, restart, pass;
  assign pass    = state == PASS;
  assign expire  = !cfg_ready_i && tcnt == TMAX;
  assign adv     = !pass && (cfg_ready_i || expire);
  // a pending replay waits for the host to drop valid so no handshake is cut off
  assign restart = pass && (pending || rerun_i) && !host_valid_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= NumInit > 0 ? INIT : PASS;
      idx        <= '0;
      tcnt       <= '0;
      pending    <= 1'b0;
      init_err_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      state <= state_n;
      if (restart) begin
        idx        <= '0;
        tcnt       <= '0;
        pending    <= 1'b0;
        init_err_o <= 1'b0;
        timeout_o  <= 1'b0;
      end else if (pass) begin
        pending <= pending | rerun_i;
      end else begin
        tcnt <= adv ? '0 : tcnt + TW'(1);
        if (cfg_ready_i) init_err_o <= init_err_o | cfg_error_i;
        if (expire) timeout_o <= 1'b1;
        if (adv && idx != LAST) idx <= idx + IW'(1);
      end
    end
  end
  always_comb begin
    state_n = restart ? INIT : (adv && idx == LAST) ? PASS : state;
  end
  always_comb begin
    cfg_valid_o  = pass ? host_valid_i : 1'b1;
    cfg_write_o  = pass ? host_write_i : 1'b1;
    cfg_addr_o   = pass ? host_addr_i : InitAddr[idx];
    cfg_wdata_o  = pass ? host_wdata_i : InitData[idx];
    cfg_wstrb_o  = pass ? host_wstrb_i : '1;
    host_ready_o = pass & cfg_ready_i;
    host_rdata_o = pass ? cfg_rdata_i : '0;
    host_error_o = pass & cfg_error_i;
    done_o       = pass;
  end
  a_init_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (!pass && !cfg_ready_i && !expire) |=> ($stable(cfg_addr_o) && $stable(cfg_wdata_o) && cfg_valid_o));
  a_params: assert property (@(posedge clk_i)
    RegDataWidth >= 16 && (RegDataWidth & (RegDataWidth - 1)) == 0 && TimeoutCycles >= 1);
endmodule

// File: tb/tb_hyperbus_cfg_init_seq.sv
// tb_hyperbus_cfg_init_seq: directed + random stimulus against a transaction-level model of the boot sequencer.
module tb_hyperbus_cfg_init_seq;
  localparam int N = 3;
  localparam int TO = 8;
  localparam logic [N-1:0][31:0] IA = {32'h400, 32'h4, 32'h0};
  localparam logic [N-1:0][31:0] ID = {32'hAB, 32'h1, 32'h6};
  logic clk = 0, rst = 1, rerun = 0, hv = 0, hw = 0, cr = 1, ce = 0;
  logic [31:0] ha = 0, hd = 0, crd = 0;
  logic [3:0] hs = 0;
  logic h_rdy, h_err, cv, cw, done, ierr, tout;
  logic [31:0] h_rd, ca, cd;
  logic [3:0] cs;
  int vecs = 0, errs = 0, cnt;
  bit known = 0, m_pass, m_pend, m_ierr, m_tout;
  int m_idx, m_stall;
  always #5 clk = ~clk;
  hyperbus_cfg_init_seq #(
    .RegAddrWidth(32), .RegDataWidth(32), .NumInit(N),
    .InitAddr(IA), .InitData(ID), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rerun_i(rerun),
    .host_valid_i(hv), .host_write_i(hw), .host_addr_i(ha), .host_wdata_i(hd), .host_wstrb_i(hs),
    .host_ready_o(h_rdy), .host_rdata_o(h_rd), .host_error_o(h_err),
    .cfg_valid_o(cv), .cfg_write_o(cw), .cfg_addr_o(ca), .cfg_wdata_o(cd), .cfg_wstrb_o(cs),
    .cfg_ready_i(cr), .cfg_rdata_i(crd), .cfg_error_i(ce),
    .done_o(done), .init_err_o(ierr), .timeout_o(tout)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_outputs();
    if (!known) return;
    chk("cfg_valid", 32'(cv), m_pass ? 32'(hv) : 32'd1);
    chk("cfg_write", 32'(cw), m_pass ? 32'(hw) : 32'd1);
    chk("cfg_addr", ca, m_pass ? ha : IA[m_idx]);
    chk("cfg_wdata", cd, m_pass ? hd : ID[m_idx]);
    chk("cfg_wstrb", 32'(cs), m_pass ? 32'(hs) : 32'hF);
    chk("host_ready", 32'(h_rdy), 32'(m_pass & cr));
    chk("host_rdata", h_rd, m_pass ? crd : 32'd0);
    chk("host_error", 32'(h_err), 32'(m_pass & ce));
    chk("done", 32'(done), 32'(m_pass));
    chk("init_err", 32'(ierr), 32'(m_ierr));
    chk("timeout", 32'(tout), 32'(m_tout));
  endtask
  // one boot entry ends when it is accepted or after TO consecutive refused cycles
  task automatic model_clock();
    bit fin;
    fin = 0;
    if (rst) begin
      m_pass = 0; m_idx = 0; m_stall = 0; m_pend = 0; m_ierr = 0; m_tout = 0; known = 1;
    end else if (!m_pass) begin
      if (cr) begin
        m_ierr |= ce;
        fin = 1;
      end else begin
        m_stall++;
        if (m_stall == TO) begin
          m_tout = 1;
          fin = 1;
        end
      end
      if (fin) begin
        m_stall = 0;
        if (m_idx == N - 1) m_pass = 1;
        else m_idx++;
      end
    end else if ((m_pend || rerun) && !hv) begin
      m_pass = 0; m_idx = 0; m_stall = 0; m_pend = 0; m_ierr = 0; m_tout = 0;
    end else begin
      m_pend |= rerun;
    end
  endtask
  task automatic step();
    #2;
    check_outputs();
    @(posedge clk);
    model_clock();
    #1;
  endtask
  initial begin
    step();
    step();
    rst = 0;
    cnt = 0;
    while (!done && cnt < 100) begin step(); cnt++; end
    chk("boot_latency", cnt, N);
    hv = 1; hw = 0; ha = 32'h8; crd = 32'h1234;
    step();
    hv = 0;
    step();
    hv = 1; hw = 1; ha = 32'h10; hd = 32'h55; hs = 4'hF; cr = 0; rerun = 1;
    step();
    rerun = 0;
    step();
    step();
    cr = 1;
    step();
    hv = 0;
    step();
    chk("rerun_enters_init", 32'(done), 32'd0);
    hv = 1; hw = 0; ha = 32'h8; cr = 0;
    repeat (5) step();
    cr = 1;
    step();
    step();
    ce = 1;
    step();
    ce = 0; hv = 0;
    chk("init_err_sticky", 32'(ierr), 32'd1);
    chk("done_after_err", 32'(done), 32'd1);
    rerun = 1;
    step();
    rerun = 0; cr = 0;
    cnt = 0;
    while (!done && cnt < 100) begin step(); cnt++; end
    chk("timeout_latency", cnt, N * TO);
    chk("timeout_flag", 32'(tout), 32'd1);
    cr = 1; rerun = 1;
    step();
    rerun = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("restart_addr", ca, IA[0]);
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom % 200) == 0;
      rerun = ($urandom % 25) == 0;
      hv = $urandom % 2;
      hw = $urandom % 2;
      ha = $urandom;
      hd = $urandom;
      hs = 4'($urandom);
      crd = $urandom;
      cr = (i % 97 < 12) ? 1'b0 : (($urandom % 4) != 0);
      ce = ($urandom % 8) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
